board_ctrl: RTL and testbench

Owner and write sequencer for the 64-square board register file. It serializes three kinds of update into a single internal write port: the initial-position load, two-write move commits, and, when configured, one-level undo. It drives the flattened board bus read by the game logic and display units. It sits between the logic unit (requester) and the display unit (reader), replacing ad-hoc board writes in the top level.

---
 rtl/board_ctrl_if.sv | 33 +++
 rtl/board_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_board_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_ctrl_if.sv
// Request/status bundle between the move requester and board_ctrl.
// undo_req exists only when MOVE_UNDO_EN is defined.
interface board_ctrl_if;
  logic         init_req;
  logic         mv_req;
  logic [5:0]   mv_src;
  logic [5:0]   mv_dst;
  logic [3:0]   mv_piece;
`ifdef MOVE_UNDO_EN
  logic         undo_req;
`endif
  logic         busy;
  logic         ack;
  logic         init_done;
  logic [3:0]   last_capture;
  logic [255:0] board_flat;

  modport master (
    output init_req, mv_req, mv_src, mv_dst, mv_piece,
`ifdef MOVE_UNDO_EN
    output undo_req,
`endif
    input  busy, ack, init_done, last_capture, board_flat
  );

  modport slave (
    input  init_req, mv_req, mv_src, mv_dst, mv_piece,
`ifdef MOVE_UNDO_EN
    input  undo_req,
`endif
    output busy, ack, init_done, last_capture, board_flat
  );
endinterface

// File: rtl/board_ctrl.sv
// 64x4 board register file with a single write port sequencing init load (64 writes), moves (2 writes)
// and optional one-level undo (MOVE_UNDO_EN); ack pulses in DONE, requests only sampled in IDLE.
module board_ctrl (
  input logic         clk,
  input logic         rst,
  board_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MV_DST,
    S_MV_SRC,
    S_DONE
`ifdef MOVE_UNDO_EN
    ,
    S_UNDO_SRC,
    S_UNDO_DST
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q;
  logic         op_init_q;
  logic [5:0]   src_q, dst_q;
  logic [3:0]   piece_q, capture_q;
  logic [255:0] board_q;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [3:0]   wr_dat;
  logic         same_sq;

`ifdef MOVE_UNDO_EN
  logic [5:0]   u_src_q, u_dst_q;
  logic [3:0]   u_piece_q, u_cap_q;
  logic         u_vld_q;
`endif

  assign same_sq = (src_q == dst_q);

  // Back-rank order R N B Q K B N R by file.
  function automatic logic [2:0] back_rank(input logic [2:0] f);
    case (f)
      3'd0, 3'd7: back_rank = 3'd4;
      3'd1, 3'd6: back_rank = 3'd2;
      3'd2, 3'd5: back_rank = 3'd3;
      3'd3:       back_rank = 3'd5;
      default:    back_rank = 3'd6;
    endcase
  endfunction

  function automatic logic [3:0] init_piece(input logic [5:0] sq);
    case (sq[5:3])
      3'd0:    init_piece = {1'b1, back_rank(sq[2:0])};
      3'd1:    init_piece = 4'h9;
      3'd6:    init_piece = 4'h1;
      3'd7:    init_piece = {1'b0, back_rank(sq[2:0])};
      default: init_piece = 4'h0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.init_req)    state_d = S_INIT;
        else if (bus.mv_req) state_d = S_MV_DST;
`ifdef MOVE_UNDO_EN
        else if (bus.undo_req) state_d = S_UNDO_SRC;
`endif
      end
      S_INIT:     if (cnt_q == 6'd63) state_d = S_DONE;
      S_MV_DST:   state_d = S_MV_SRC;
      S_MV_SRC:   state_d = S_DONE;
`ifdef MOVE_UNDO_EN
      S_UNDO_SRC: state_d = S_UNDO_DST;
      S_UNDO_DST: state_d = S_DONE;
`endif
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_dat  = 4'h0;
    case (state_q)
      S_INIT: begin
        wr_en  = 1'b1;
        wr_dat = init_piece(cnt_q);
      end
      S_MV_DST: begin
        wr_en   = !same_sq;
        wr_addr = dst_q;
        wr_dat  = piece_q;
      end
      S_MV_SRC: begin
        wr_en   = !same_sq;
        wr_addr = src_q;
      end
`ifdef MOVE_UNDO_EN
      S_UNDO_SRC: begin
        wr_en   = u_vld_q;
        wr_addr = u_src_q;
        wr_dat  = u_piece_q;
      end
      S_UNDO_DST: begin
        wr_en   = u_vld_q;
        wr_addr = u_dst_q;
        wr_dat  = u_cap_q;
      end
`endif
      default: ;
    endcase
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.ack          = (state_q == S_DONE);
  assign bus.init_done    = (state_q == S_DONE) && op_init_q;
  assign bus.last_capture = capture_q;
  assign bus.board_flat   = board_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       board_q <= '0;
    else if (wr_en) board_q[{wr_addr, 2'b00} +: 4] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 6'd0;
      op_init_q <= 1'b0;
      src_q     <= 6'd0;
      dst_q     <= 6'd0;
      piece_q   <= 4'h0;
      capture_q <= 4'h0;
`ifdef MOVE_UNDO_EN
      u_src_q   <= 6'd0;
      u_dst_q   <= 6'd0;
      u_piece_q <= 4'h0;
      u_cap_q   <= 4'h0;
      u_vld_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q     <= 6'd0;
          op_init_q <= (state_d == S_INIT);
          if (state_d == S_MV_DST) begin
            src_q   <= bus.mv_src;
            dst_q   <= bus.mv_dst;
            piece_q <= bus.mv_piece;
          end
        end
        S_INIT: begin
          cnt_q <= cnt_q + 6'd1;
`ifdef MOVE_UNDO_EN
          if (cnt_q == 6'd63) u_vld_q <= 1'b0;
`endif
        end
        S_MV_DST: if (!same_sq) capture_q <= board_q[{dst_q, 2'b00} +: 4];
`ifdef MOVE_UNDO_EN
        // capture_q already holds the displaced piece from the MV_DST cycle.
        S_MV_SRC: if (!same_sq) begin
          u_src_q   <= src_q;
          u_dst_q   <= dst_q;
          u_piece_q <= board_q[{src_q, 2'b00} +: 4];
          u_cap_q   <= capture_q;
          u_vld_q   <= 1'b1;
        end
        S_UNDO_DST: u_vld_q <= 1'b0;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: init load, move table, reset abort, request priority, optional undo.
module tb_board_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  board_ctrl_if bus();
  board_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] sq;
    logic [3:0] exp;
  } sq_vec_t;

  typedef struct {
    logic [5:0] src;
    logic [5:0] dst;
    logic [3:0] piece;
    logic [3:0] exp_dst;
    logic [3:0] exp_src;
    logic [3:0] exp_cap;
  } mv_vec_t;

  sq_vec_t      sq_tab [8];
  mv_vec_t      mv_tab [4];
  logic [255:0] init_ref;
  logic [255:0] ref_board;

  function automatic logic [3:0] sq_of(input logic [255:0] b, input logic [5:0] s);
    return b[{s, 2'b00} +: 4];
  endfunction

  function automatic logic [255:0] build_init();
    logic [255:0] b;
    logic [3:0]   back [8];
    back = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    b = '0;
    for (int f = 0; f < 8; f++) begin
      b[f*4 +: 4]      = back[f] | 4'h8;
      b[(8+f)*4 +: 4]  = 4'h9;
      b[(48+f)*4 +: 4] = 4'h1;
      b[(56+f)*4 +: 4] = back[f];
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      tick();
      if (bus.busy) break;
    end
    chk(name, 32'(bus.busy), 1);
  endtask

  // Ack is observed after edge N+64, i.e. sampled high at edge N+65.
  task automatic do_init(input string tag);
    int n;
    bus.init_req = 1'b1;
    wait_busy({tag, "_accept"}, 8);
    n = 0;
    while (!bus.ack && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_ack_lat"}, 32'(n), 64);
    chk({tag, "_init_done"}, 32'(bus.init_done), 1);
    chkb({tag, "_board"}, bus.board_flat, init_ref);
    bus.init_req = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, 32'(bus.ack), 0);
    chk({tag, "_idle"}, 32'(bus.busy), 0);
  endtask

  // Operands are scrambled right after acceptance to confirm they were latched.
  task automatic do_move(input mv_vec_t v, input string tag, input int lim);
    bus.mv_src   = v.src;
    bus.mv_dst   = v.dst;
    bus.mv_piece = v.piece;
    bus.mv_req   = 1'b1;
    wait_busy({tag, "_accept"}, lim);
    bus.mv_src   = ~v.src;
    bus.mv_dst   = ~v.dst;
    bus.mv_piece = ~v.piece;
    tick();
    chk({tag, "_dst_n1"}, 32'(sq_of(bus.board_flat, v.dst)), 32'(v.exp_dst));
    chk({tag, "_ack_n1"}, 32'(bus.ack), 0);
    tick();
    chk({tag, "_src_n2"}, 32'(sq_of(bus.board_flat, v.src)), 32'(v.exp_src));
    chk({tag, "_ack_n3"}, 32'(bus.ack), 1);
    chk({tag, "_init_done"}, 32'(bus.init_done), 0);
    bus.mv_req = 1'b0;
    tick();
    chk({tag, "_ack_end"}, 32'(bus.ack), 0);
    chk({tag, "_busy_end"}, 32'(bus.busy), 0);
    chk({tag, "_capture"}, 32'(bus.last_capture), 32'(v.exp_cap));
    if (v.src != v.dst) begin
      ref_board[{v.dst, 2'b00} +: 4] = v.piece;
      ref_board[{v.src, 2'b00} +: 4] = 4'h0;
    end
    chkb({tag, "_board"}, bus.board_flat, ref_board);
  endtask

`ifdef MOVE_UNDO_EN
  task automatic do_undo(input string tag, input logic [255:0] exp_board);
    bus.undo_req = 1'b1;
    wait_busy({tag, "_accept"}, 8);
    tick();
    tick();
    chk({tag, "_ack"}, 32'(bus.ack), 1);
    bus.undo_req = 1'b0;
    tick();
    chk({tag, "_busy_end"}, 32'(bus.busy), 0);
    chkb({tag, "_board"}, bus.board_flat, exp_board);
  endtask
`endif

  initial begin
    logic any_ack;
    mv_vec_t mv2;

    init_ref     = build_init();
    bus.init_req = 1'b0;
    bus.mv_req   = 1'b0;
    bus.mv_src   = 6'd0;
    bus.mv_dst   = 6'd0;
    bus.mv_piece = 4'h0;
`ifdef MOVE_UNDO_EN
    bus.undo_req = 1'b0;
`endif

    sq_tab[0] = '{6'd0,  4'hC};
    sq_tab[1] = '{6'd4,  4'hE};
    sq_tab[2] = '{6'd8,  4'h9};
    sq_tab[3] = '{6'd63, 4'h4};
    sq_tab[4] = '{6'd60, 4'h6};
    sq_tab[5] = '{6'd3,  4'hD};
    sq_tab[6] = '{6'd52, 4'h1};
    sq_tab[7] = '{6'd20, 4'h0};

    mv_tab[0] = '{6'o14, 6'o34, 4'h9, 4'h9, 4'h0, 4'h0};
    mv_tab[1] = '{6'o64, 6'o44, 4'h1, 4'h1, 4'h0, 4'h0};
    mv_tab[2] = '{6'o01, 6'o67, 4'hA, 4'hA, 4'h0, 4'h1};
    mv_tab[3] = '{6'o00, 6'o00, 4'h5, 4'hC, 4'hC, 4'h1};

    #50;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_init_done", 32'(bus.init_done), 0);
    chk("rst_capture", 32'(bus.last_capture), 0);
    chkb("rst_board", bus.board_flat, '0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.busy), 0);

    do_init("init1");
    for (int i = 0; i < 8; i++)
      chk($sformatf("init_sq%0d", sq_tab[i].sq), 32'(sq_of(bus.board_flat, sq_tab[i].sq)),
          32'(sq_tab[i].exp));
    chkb("init_ranks2_5", {64'd0, bus.board_flat[191:64], 64'd0}, '0);

    ref_board = init_ref;
    for (int i = 0; i < 4; i++) do_move(mv_tab[i], $sformatf("mv%0d", i), 8);

    // Reset in the middle of INIT, then a clean init.
    bus.init_req = 1'b1;
    wait_busy("abort_accept", 8);
    any_ack = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      any_ack |= bus.ack;
    end
    rst = 1'b0;
    #5;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_ack", 32'(bus.ack | any_ack), 0);
    chkb("abort_board", bus.board_flat, '0);
    chk("abort_capture", 32'(bus.last_capture), 0);
    bus.init_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_init("init2");

    // Simultaneous init and move: init wins, move follows at the first IDLE cycle.
    mv2 = '{6'o06, 6'o25, 4'hA, 4'hA, 4'h0, 4'h0};
    bus.mv_src   = mv2.src;
    bus.mv_dst   = mv2.dst;
    bus.mv_piece = mv2.piece;
    bus.mv_req   = 1'b1;
    do_init("prio_init");
    ref_board = init_ref;
    do_move(mv2, "prio_mv", 1);

`ifdef MOVE_UNDO_EN
    do_init("init3");
    ref_board = init_ref;
    do_move('{6'o14, 6'o34, 4'h9, 4'h9, 4'h0, 4'h0}, "undo_mv", 8);
    do_undo("undo1", init_ref);
    do_undo("undo2", init_ref);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
